// File: rtl/gcd_req_if.sv
// Bus bundle for gcd_req: upstream operand handshake, engine start/done
// link and downstream result handshake. "master" is the controller view,
// "slave" is the view of the surrounding logic (host, engine, sink).
interface gcd_req_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic [WIDTH-1:0] gcd_a_in;
    logic [WIDTH-1:0] gcd_b_in;
    logic             gcd_start;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;

    modport master (
        input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        output in_ready, gcd_a_in, gcd_b_in, gcd_start, out_valid, out_result, out_err
    );

    modport slave (
        output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        input  in_ready, gcd_a_in, gcd_b_in, gcd_start, out_valid, out_result, out_err
    );
endinterface

// File: rtl/gcd_req.sv
// gcd_req: initiator-side controller for the gcd engine start/done protocol.
// Operand pairs are queued in a DEPTH-entry FIFO, issued one at a time to the
// engine and the results handed downstream in push order. Pairs with a zero
// operand are answered locally (GCD(0,x) = x) without an engine call.
// Optional macro GCD_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles that
// returns an all-ones result with out_err=1; without it out_err is tied low.
//
// state | meaning
// IDLE  | waiting for a queued pair; pops the head when one is present
// ISSUE | one-cycle gcd_start pulse, operands already on gcd_a_in/gcd_b_in
// WAIT  | waiting for gcd_done (or the watchdog when enabled)
// HOLD  | result presented with out_valid until out_ready
module gcd_req #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic      clk,
    input  logic      reset_n,
    gcd_req_if.master bus,
    output logic      busy
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state;
    state_t             state_nx;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;
    logic [PW:0]        count_nx;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic               head_zero;
    logic               cap_done;

    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head_a    = mem[rd_ptr][2*WIDTH-1:WIDTH];
    assign head_b    = mem[rd_ptr][WIDTH-1:0];
    assign head_zero = (head_a == '0) || (head_b == '0);
    assign count_nx  = count + (PW+1)'(push) - (PW+1)'(pop);

    assign bus.gcd_start = (state == ISSUE);
    assign bus.out_valid = (state == HOLD);
    assign busy          = (count != '0) || (state != IDLE);

`ifdef GCD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          err_q;

    assign bus.out_err = err_q;

    // watchdog: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (reset_n) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign bus.out_err    = 1'b0;
`endif

    // FIFO storage, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers, occupancy and the registered in_ready
    always_ff @(posedge clk) begin
        if (reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count        <= count_nx;
            bus.in_ready <= (count_nx != (PW+1)'(DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and result-capture strobes
    always_comb begin
        state_nx = state;
        cap_done = 1'b0;
`ifdef GCD_TIMEOUT_EN
        tmo_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nx = head_zero ? HOLD : ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.gcd_done) begin
                    state_nx = HOLD;
                    cap_done = 1'b1;
                end
`ifdef GCD_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_nx = HOLD;
                    tmo_hit  = 1'b1;
                end
`endif
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand and result registers, stable between their load points
    always_ff @(posedge clk) begin
        if (reset_n) begin
            bus.gcd_a_in   <= '0;
            bus.gcd_b_in   <= '0;
            bus.out_result <= '0;
`ifdef GCD_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
        end else begin
            if (pop) begin
                bus.gcd_a_in <= head_a;
                bus.gcd_b_in <= head_b;
                if (head_zero) begin
                    bus.out_result <= head_a | head_b;
`ifdef GCD_TIMEOUT_EN
                    err_q          <= 1'b0;
`endif
                end
            end
            if (cap_done) begin
                bus.out_result <= bus.gcd_result;
`ifdef GCD_TIMEOUT_EN
                err_q          <= 1'b0;
`endif
            end
`ifdef GCD_TIMEOUT_EN
            if (tmo_hit) begin
                bus.out_result <= '1;
                err_q          <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_gcd_req.sv
// Testbench for gcd_req: table of operand pairs with known GCDs, a behavioural
// engine answering start with done a fixed number of cycles later, and a
// scoreboard queue of expected {err, result} checked at each output handshake.
`timescale 1ns/1ps
module tb_gcd_req;
    localparam int W       = 32;
    localparam int ENG_LAT = 5;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;

    always #5 clk = ~clk;

    gcd_req_if #(.WIDTH(W)) bus ();

    gcd_req #(.WIDTH(W), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t           vecs [10];
    logic [W:0]     sb_q [$];
    logic [2*W-1:0] iss_q [$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_starts = 0;
    int             eng_cnt  = 0;
    logic [W-1:0]   eng_res;
    bit             eng_mute = 1'b0;
    bit             inj_done = 1'b0;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            chk("push_wait_in_ready", 0, 1);
        end else begin
            sb_q.push_back(exp);
            if (a != 0 && b != 0) iss_q.push_back({a, b});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || busy) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_done", (w < 400), 1);
    endtask

    // behavioural engine: done ENG_LAT cycles after each start
    initial begin
        bus.gcd_done   = 1'b0;
        bus.gcd_result = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.gcd_done = 1'b0;
            if (inj_done) begin
                bus.gcd_done = 1'b1;
                inj_done     = 1'b0;
            end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && !eng_mute) begin
                    bus.gcd_done   = 1'b1;
                    bus.gcd_result = eng_res;
                end
            end
            if (bus.gcd_start) begin
                n_starts++;
                if (iss_q.size() == 0) begin
                    chk("start_expected", 0, 1);
                end else begin
                    chk("start_operands", {bus.gcd_a_in, bus.gcd_b_in}, iss_q.pop_front());
                end
                eng_res = gcd_f(bus.gcd_a_in, bus.gcd_b_in);
                eng_cnt = ENG_LAT;
            end
        end
    end

    // scoreboard: compare each accepted result against the oldest expectation
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("out_expected", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_result", bus.out_result, e[W-1:0]);
                    chk("out_err", bus.out_err, e[W]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0, w, c;
        bit   seen;
        logic [W-1:0] bp_a [6];
        logic [W-1:0] bp_b [6];

        vecs[0] = '{48, 18, 6};
        vecs[1] = '{0, 35, 35};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{17, 5, 1};
        vecs[4] = '{100, 75, 25};
        vecs[5] = '{7, 0, 7};
        vecs[6] = '{1024, 96, 32};
        vecs[7] = '{81, 27, 27};
        vecs[8] = '{13, 13, 13};
        vecs[9] = '{36, 84, 12};
        bp_a = '{48, 17, 35, 64, 9, 100};
        bp_b = '{18, 5, 10, 48, 12, 40};

        reset_n       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_gcd_start", bus.gcd_start, 0);
        chk("rst_gcd_a_in", bus.gcd_a_in, 0);
        chk("rst_gcd_b_in", bus.gcd_b_in, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b0;
        @(negedge clk);

        // table of pairs streamed back to back
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_pair(vecs[i].a, vecs[i].b, {1'b0, vecs[i].exp});
        end
        drain();

        // basic engine path and done-to-valid latency
        s0 = n_starts;
        push_pair(48, 18, {1'b0, 32'd6});
        w = 0;
        while (!bus.gcd_done && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("basic_done_seen", (w < 50), 1);
        chk("basic_ov_in_done_cycle", bus.out_valid, 0);
        @(negedge clk);
        chk("basic_ov_after_done", bus.out_valid, 1);
        chk("basic_out_result", bus.out_result, 6);
        chk("basic_one_start", n_starts - s0, 1);
        chk("basic_a_in", bus.gcd_a_in, 48);
        chk("basic_b_in", bus.gcd_b_in, 18);
        drain();

        // zero bypass: no engine call, valid two cycles after push
        s0 = n_starts;
        push_pair(0, 35, {1'b0, 32'd35});
        chk("zb_ov_early", bus.out_valid, 0);
        @(negedge clk);
        chk("zb_ov_two_cycles", bus.out_valid, 1);
        chk("zb_result", bus.out_result, 35);
        drain();
        push_pair(0, 0, {1'b0, 32'd0});
        drain();
        chk("zb_no_start", n_starts - s0, 0);

        // backpressure: 4 queued plus 1 held fills the controller
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_pair(bp_a[i], bp_b[i], {1'b0, gcd_f(bp_a[i], bp_b[i])});
        end
        repeat (12) @(negedge clk);
        chk("bp_in_ready_full", bus.in_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_ov_held", bus.out_valid, 1);
        chk("bp_result_held", bus.out_result, 6);
        repeat (2) @(negedge clk);
        chk("bp_result_stable", bus.out_result, 6);
        bus.out_ready = 1'b1;
        push_pair(bp_a[5], bp_b[5], {1'b0, gcd_f(bp_a[5], bp_b[5])});
        drain();

        // reset while waiting on the engine, done in the cycle after reset
        eng_mute = 1'b1;
        s0       = n_starts;
        push_pair(10, 4, {1'b0, 32'd2});
        w = 0;
        while (n_starts == s0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_wait_started", (w < 20), 1);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        inj_done = 1'b1;
        sb_q.delete();
        iss_q.delete();
        eng_cnt  = 0;
        @(negedge clk);
        reset_n  = 1'b0;
        eng_mute = 1'b0;
        seen     = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst_mid_no_out_valid", seen, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);

        // stray done while idle
        s0       = n_starts;
        inj_done = 1'b1;
        seen     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid || busy) seen = 1'b1;
        end
        chk("stray_done_ignored", seen, 0);
        chk("stray_no_start", n_starts - s0, 0);

`ifdef GCD_TIMEOUT_EN
        // engine never answers: watchdog result, then the next pair proceeds
        eng_mute = 1'b1;
        s0       = n_starts;
        push_pair(21, 14, {1'b1, {W{1'b1}}});
        push_pair(9, 6, {1'b0, 32'd3});
        chk("tmo_one_start", n_starts - s0, 1);
        c = 0;
        while (!bus.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_issue_to_valid", c, 17);
        chk("tmo_err", bus.out_err, 1);
        chk("tmo_result", bus.out_result, {W{1'b1}});
        eng_mute = 1'b0;
        inj_done = 1'b1;
        drain();
        chk("tmo_next_issued", n_starts - s0, 2);
`endif

        drain();
        chk("sb_empty", sb_q.size(), 0);
        chk("iss_empty", iss_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_req.md
Name: gcd_req

Overview:
- Initiator-side controller for the gcd engine's start/done protocol.
- Accepts operand pairs from upstream on a valid/ready interface and buffers them in a small FIFO.
- Issues each pair to the engine with a one-cycle start pulse, waits for done, and captures the result.
- Presents each result downstream on a valid/ready interface. Sits between the test/host logic and the gcd engine.

Parameters:
- WIDTH, 32, operand/result width.
- DEPTH, 4, operand FIFO entries (power of 2, >=2).
- TIMEOUT, 1024, max cycles waiting for done (used only with GCD_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous reset, active-high (asserted = 1 resets on next posedge).
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- gcd_a_in  out  WIDTH  to engine a_in.
- gcd_b_in  out  WIDTH  to engine b_in.
- gcd_start  out  1  one-cycle start pulse to engine.
- gcd_done  in  1  engine result valid.
- gcd_result  in  WIDTH  engine result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  GCD result.
- out_err  out  1  result is a timeout error (qualified by out_valid).
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset values: in_ready=1, gcd_start=0, gcd_a_in=0, gcd_b_in=0, out_valid=0, out_result=0, out_err=0, busy=0. FIFO pointers and count are 0; FSM is IDLE.
- Reset mid-operation:
  - Discards the FIFO contents and any in-flight request.
  - A gcd_done arriving in the cycle after reset is ignored.
- Input handshake:
  - Push when in_valid && in_ready.
  - in_ready = (count != DEPTH), registered from count.
  - Push and pop in the same cycle leave count unchanged. A push to a full FIFO is impossible because in_ready=0.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop the head into gcd_a_in/gcd_b_in.
  - If head a==0 or b==0: load out_result = a|b (GCD(0,x)=x; GCD(0,0)=0), out_err=0, go to HOLD. No engine call.
  - Otherwise go to ISSUE.
- ISSUE:
  - gcd_start=1 for exactly this cycle; operands are stable on gcd_a_in/gcd_b_in from this cycle until done.
  - Next state is WAIT.
- WAIT:
  - On gcd_done=1: capture gcd_result into out_result, out_err=0, go to HOLD.
  - A done in the ISSUE cycle itself is ignored.
- HOLD:
  - out_valid=1; out_result and out_err are held stable until out_ready.
  - On out_valid && out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - out_ready may be asserted before out_valid; it has no effect then.
- Latency:
  - Zero-bypass: push to out_valid = 2 cycles when the FIFO was empty and the FSM was IDLE.
  - Engine path: out_valid asserts 1 cycle after the gcd_done cycle.
- Ordering: results leave strictly in push order; one request is outstanding at the engine at a time.
- busy = (count != 0) || (state != IDLE).
- gcd_done outside WAIT is ignored.

Optional Feature:
- GCD_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without gcd_done: out_result = all ones, out_err=1, go to HOLD.
  - A late gcd_done after the timeout is ignored (the FSM is no longer in WAIT).
- Not defined:
  - No counter is synthesized; WAIT lasts indefinitely until gcd_done.
  - out_err is tied to 0.

Test Plan:
- Basic path: push (48,18); engine model answers done=1/result=6 five cycles after start -> exactly one start pulse with gcd_a_in=48, gcd_b_in=18; out_valid with out_result=6, out_err=0 one cycle after done.
- Zero bypass:
  - Push (0,35) -> out_result=35 after 2 cycles with no gcd_start pulse.
  - Push (0,0) -> out_result=0.
- Backpressure/full:
  - Hold out_ready=0 and push 6 pairs (DEPTH=4) -> in_ready drops after 4 queued plus 1 in flight.
  - Release out_ready -> results 6,1,5,... emerge in push order with no loss or duplication.
- Reset mid-WAIT: assert reset_n=1 for one cycle while in WAIT, then pulse gcd_done -> no out_valid; busy=0, in_ready=1 after reset.
- Timeout (GCD_TIMEOUT_EN, TIMEOUT=16): start issued, done never returns -> after 16 WAIT cycles out_valid=1, out_err=1, out_result=0xFFFFFFFF; a late done is ignored and the next queued pair is then issued normally.
- Stray done: pulse gcd_done while IDLE with an empty FIFO -> no out_valid and no state change.
